tb_axi_stream_slave: RTL and testbench

AXI-Stream slave sink that accepts 16-bit stream words, serializes each word into bytes on a byte-wide diagnostic write port, and raises a sticky done flag once the packet marked by `tlast` has been fully reported. It is the device exercised by the AXI-Stream-slave peripheral bench. The diagnostic port feeds a logger, and `o_done` terminates the simulation.

---
 rtl/axis_diag_pkg.sv | 17 +
 rtl/axis_diag_serializer.sv | 53 +++++
 rtl/tb_axi_stream_slave.sv | 129 ++++++++++++
 tb/tb_tb_axi_stream_slave.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_diag_pkg.sv
// Shared types and constants for the AXI-Stream diagnostic sink.
package axis_diag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    TRAIL,
    DONE
  } state_e;

  localparam logic [7:0] RST_BYTE = 8'h00;

  function automatic int unsigned idx_width(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/axis_diag_serializer.sv
// Holds one accepted stream word and walks its bytes out, one per cycle,
// flagging the final byte so the controller can decide what follows.
module axis_diag_serializer
  import axis_diag_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [7:0]            byte_o,
  output logic                  strobe_o,
  output logic                  last_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned IW = idx_width(NB);

  logic [DATA_WIDTH-1:0] word_q;
  logic [IW-1:0]         idx_q;
  logic                  busy_q;
  logic [IW-1:0]         sel;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_q <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      word_q <= word_i;
      idx_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      idx_q <= idx_q + 1'b1;
      if (last_o) busy_q <= 1'b0;
    end
  end

  // Byte order is resolved by mirroring the index rather than the word.
  always_comb begin
    sel    = (MSB_FIRST != 0) ? (IW'(NB - 1) - idx_q) : idx_q;
    byte_o = RST_BYTE;
    for (int unsigned i = 0; i < NB; i++) begin
      if (sel == i[IW-1:0]) byte_o = word_q[i*8 +: 8];
    end
  end

  assign strobe_o = busy_q;
  assign last_o   = busy_q && (idx_q == IW'(NB - 1));

endmodule

// File: rtl/tb_axi_stream_slave.sv
// AXI-Stream sink reporting each word bytewise on a diagnostic port.
// Define AXIS_DIAG_TRAILER_EN to append word count and XOR checksum per packet.
module tb_axi_stream_slave
  import axis_diag_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic [7:0]            o_diag,
  output logic                  o_diag_wr,
  output logic                  o_done
);

  state_e     state_q;
  logic       ready_q;
  logic       last_q;
  logic [7:0] diag_q;
  logic       wr_q;
  logic       done_q;
  logic       hs;
  logic [7:0] ser_byte;
  logic       ser_strobe;
  logic       ser_last;
`ifdef AXIS_DIAG_TRAILER_EN
  logic [7:0] cnt_q;
  logic [7:0] csum_q;
  logic       trail_q;
`endif

  assign hs = s_axis_tvalid & ready_q;

  axis_diag_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_ser (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .start_i (hs),
    .word_i  (s_axis_tdata),
    .byte_o  (ser_byte),
    .strobe_o(ser_strobe),
    .last_o  (ser_last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      diag_q  <= RST_BYTE;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef AXIS_DIAG_TRAILER_EN
      cnt_q   <= RST_BYTE;
      csum_q  <= RST_BYTE;
      trail_q <= 1'b0;
`endif
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (hs) begin
            ready_q <= 1'b0;
            last_q  <= s_axis_tlast;
            state_q <= EMIT;
`ifdef AXIS_DIAG_TRAILER_EN
            cnt_q   <= cnt_q + 8'd1;
`endif
          end
        end
        EMIT: begin
          if (ser_strobe) begin
            diag_q <= ser_byte;
            wr_q   <= 1'b1;
`ifdef AXIS_DIAG_TRAILER_EN
            csum_q <= csum_q ^ ser_byte;
`endif
            // Re-arming ready here gives the NB+1 cycle handshake spacing.
            if (ser_last) begin
              if (!last_q) begin
                state_q <= IDLE;
                ready_q <= 1'b1;
              end else begin
`ifdef AXIS_DIAG_TRAILER_EN
                state_q <= TRAIL;
                trail_q <= 1'b0;
`else
                state_q <= DONE;
`endif
              end
            end
          end
        end
`ifdef AXIS_DIAG_TRAILER_EN
        TRAIL: begin
          wr_q <= 1'b1;
          if (!trail_q) begin
            diag_q  <= cnt_q;
            trail_q <= 1'b1;
          end else begin
            diag_q  <= csum_q;
            cnt_q   <= RST_BYTE;
            csum_q  <= RST_BYTE;
            state_q <= DONE;
          end
        end
`endif
        DONE: begin
          ready_q <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = ready_q;
  assign o_diag        = diag_q;
  assign o_diag_wr     = wr_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_tb_axi_stream_slave.sv
// Directed bench for tb_axi_stream_slave: MSB-first instance plus an LSB-first instance.
module tb_tb_axi_stream_slave;

  logic        clk;
  logic        rst;
  logic        tvalid, tlast;
  logic [15:0] tdata;
  logic        tready;
  logic [7:0]  diag;
  logic        diag_wr, done;
  logic        lvalid, llast;
  logic [15:0] ldata;
  logic        lready;
  logic [7:0]  ldiag;
  logic        ldiag_wr, ldone;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  logic done_prev = 1'b0;
  logic [7:0] q[$];
  logic [7:0] lq[$];

  tb_axi_stream_slave #(.DATA_WIDTH(16), .MSB_FIRST(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tdata(tdata),
    .o_diag(diag), .o_diag_wr(diag_wr), .o_done(done)
  );

  tb_axi_stream_slave #(.DATA_WIDTH(16), .MSB_FIRST(0)) dut_lsb (
    .i_clk(clk), .i_rst(rst),
    .s_axis_tvalid(lvalid), .s_axis_tready(lready), .s_axis_tlast(llast), .s_axis_tdata(ldata),
    .o_diag(ldiag), .o_diag_wr(ldiag_wr), .o_done(ldone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (diag_wr) begin
      q.push_back(diag);
      last_wr_cyc = cyc;
    end
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
    if (ldiag_wr) lq.push_back(ldiag);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l, input int gap, output int hs);
    int n;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    n = 0;
    while (tready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("hs_timeout", 32'(n < 64), 1);
    @(negedge clk);
    hs = cyc;
    tvalid = 1'b0;
    chk("tready_after_hs", 32'(tready), 0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(done), 1);
    @(negedge clk);
    chk("done_latency", done_cyc, last_wr_cyc + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] words[10];
    logic [7:0]  exp[$];
    int base, hs1, hs2;

    rst = 1'b1;
    tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    lvalid = 1'b0; llast = 1'b0; ldata = '0;
    repeat (3) @(negedge clk);
    chk("rst_tready", 32'(tready), 0);
    chk("rst_diag_wr", 32'(diag_wr), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_release", 32'(tready), 1);

    // LSB-first instance: 0x1234 -> 34 12
    lvalid = 1'b1; ldata = 16'h1234; llast = 1'b1;
    @(negedge clk);
    lvalid = 1'b0;
    repeat (6) @(negedge clk);
    chk("lsb_count", lq.size(), 2);
    if (lq.size() == 2) begin
      chk("lsb_byte0", 32'(lq[0]), 32'h34);
      chk("lsb_byte1", 32'(lq[1]), 32'h12);
    end
    chk("lsb_done", 32'(ldone), 1);

    // 10-word packet with shrinking gaps
    words = '{16'h0051, 16'h0040, 16'h0031, 16'h0024, 16'h0019,
              16'h0010, 16'h0009, 16'h0004, 16'h0001, 16'h0000};
    base = q.size();
    for (int i = 0; i < 10; i++) begin
      send(words[i], (i == 9), (i == 9) ? 0 : 10 - i, hs1);
      exp.push_back(words[i][15:8]);
      exp.push_back(words[i][7:0]);
    end
`ifdef AXIS_DIAG_TRAILER_EN
    exp.push_back(8'h0A);
    exp.push_back(8'h01);
`endif
    wait_done();
    chk("pkt_count", q.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (base + i < q.size()) chk($sformatf("pkt_byte%0d", i), 32'(q[base + i]), 32'(exp[i]));

    // Back-to-back: tvalid held high across two words
    do_reset();
    base = q.size();
    send(16'h1234, 1'b0, 0, hs1);
    send(16'hABCD, 1'b1, 0, hs2);
    chk("b2b_spacing", hs2 - hs1, 3);
    exp = '{8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef AXIS_DIAG_TRAILER_EN
    exp.push_back(8'h02);
    exp.push_back(8'h40);
`endif
    wait_done();
    chk("b2b_count", q.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (base + i < q.size()) chk($sformatf("b2b_byte%0d", i), 32'(q[base + i]), 32'(exp[i]));

    // Asynchronous reset after the first byte of 0x5566
    do_reset();
    base = q.size();
    send(16'h5566, 1'b0, 0, hs1);
    @(negedge clk);
    chk("abort_first_wr", 32'(diag_wr), 1);
    chk("abort_first_byte", 32'(diag), 32'h55);
    #2 rst = 1'b1;
    #1;
    chk("abort_wr_async", 32'(diag_wr), 0);
    chk("abort_tready_async", 32'(tready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tready_release", 32'(tready), 1);
    repeat (3) @(negedge clk);
    chk("abort_no_more_bytes", q.size() - base, 1);
    base = q.size();
    send(16'h0102, 1'b1, 0, hs1);
    exp = '{8'h01, 8'h02};
`ifdef AXIS_DIAG_TRAILER_EN
    exp.push_back(8'h01);
    exp.push_back(8'h03);
`endif
    wait_done();
    chk("post_rst_count", q.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (base + i < q.size()) chk($sformatf("post_rst_byte%0d", i), 32'(q[base + i]), 32'(exp[i]));

    // Words offered after done are never accepted
    base = q.size();
    tvalid = 1'b1; tdata = 16'hFFFF; tlast = 1'b0;
    repeat (10) @(negedge clk);
    chk("done_tready", 32'(tready), 0);
    chk("done_no_writes", q.size() - base, 0);
    chk("done_sticky", 32'(done), 1);
    tvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
